// File: rtl/yc_noc_pkg.sv
// yc_noc_pkg: shared flit type, default sizes and round-robin pick helper for the NoC output port.
package yc_noc_pkg;
   localparam int N_D = 5;
   localparam int FW_D = 32;
   localparam int DEPTH_D = 2;
   localparam int NMAX = 32;
   typedef struct packed {
      logic head;
      logic tail;
      logic [FW_D-1:0] payload;
   } yc_flit_t;
   // Scans from the highest offset down so the lowest offset from ptr wins.
   function automatic logic [NMAX-1:0] rr_pick(input logic [NMAX-1:0] req, input int ptr, input int n);
      logic [NMAX-1:0] g;
      int j;
      g = '0;
      for (int k = n - 1; k >= 0; k--) begin
         j = (ptr + k) % n;
         if (req[j[4:0]]) g = NMAX'(1) << j;
      end
      return g;
   endfunction
endpackage

// File: rtl/yc_noc_outport_if.sv
// yc_noc_outport_if: requester-side and link-side signals of one router output port.
// YC_NOC_OUTPORT_CREDIT_EN swaps out_ready for a credit_ret input.
interface yc_noc_outport_if #(parameter int N = 5, parameter int FW = 32);
   logic [N-1:0] in_valid;
   logic [N-1:0] in_head;
   logic [N-1:0] in_tail;
   logic [N*FW-1:0] in_flit;
   logic [N-1:0] in_ready;
   logic out_valid;
   logic [FW-1:0] out_flit;
   logic out_head;
   logic out_tail;
`ifdef YC_NOC_OUTPORT_CREDIT_EN
   logic credit_ret;
   modport slave(input in_valid, in_head, in_tail, in_flit, credit_ret,
                 output in_ready, out_valid, out_flit, out_head, out_tail);
   modport master(output in_valid, in_head, in_tail, in_flit, credit_ret,
                  input in_ready, out_valid, out_flit, out_head, out_tail);
`else
   logic out_ready;
   modport slave(input in_valid, in_head, in_tail, in_flit, out_ready,
                 output in_ready, out_valid, out_flit, out_head, out_tail);
   modport master(output in_valid, in_head, in_tail, in_flit, out_ready,
                  input in_ready, out_valid, out_flit, out_head, out_tail);
`endif
endinterface

// File: rtl/yc_noc_ofifo.sv
// yc_noc_ofifo: small synchronous FIFO of flits; head reads as zero when empty.
module yc_noc_ofifo
   import yc_noc_pkg::*;
#(
   parameter int DEPTH = DEPTH_D,
   parameter type T = yc_flit_t,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  T din,
   output T dout,
   output logic full,
   output logic empty,
   output logic [CW-1:0] count
);
   T mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push & !full;
   assign do_pop = pop & !empty;
   assign dout = empty ? T'('0) : mem[rp];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
         if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/yc_noc_outport.sv
// yc_noc_outport: packet-level round-robin output port with wormhole lock and output FIFO.
// YC_NOC_OUTPORT_CREDIT_EN replaces link ready with a saturating credit counter.
module yc_noc_outport
   import yc_noc_pkg::*;
#(
   parameter int N = N_D,
   parameter int FW = FW_D,
   parameter int DEPTH = DEPTH_D,
   parameter int CRED = 4
) (
   input logic clk,
   input logic rst,
   yc_noc_outport_if.slave p
);
   localparam int PW = N > 1 ? $clog2(N) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   typedef struct packed {
      logic head;
      logic tail;
      logic [FW-1:0] payload;
   } flit_t;
   logic locked;
   logic [PW-1:0] owner, ptr, win_idx, idx;
   logic [N-1:0] win;
   logic full, empty, acc, pop;
   logic [CW-1:0] count;
   flit_t din, dout;
   assign win = N'(rr_pick(NMAX'(p.in_valid & p.in_head), int'(ptr), N));
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) if (win[i]) win_idx = PW'(i);
   end
   assign idx = locked ? owner : win_idx;
   assign p.in_ready = rst | full ? '0 : locked ? N'(1) << owner : win;
   assign acc = |(p.in_valid & p.in_ready);
   assign din = '{head: p.in_head[idx], tail: p.in_tail[idx], payload: p.in_flit[idx*FW +: FW]};
   // Any accepted flit without a tail leaves (or keeps) the port locked to its sender.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked <= 1'b0;
         owner <= '0;
         ptr <= '0;
      end else if (acc) begin
         locked <= !p.in_tail[idx];
         if (p.in_head[idx]) begin
            owner <= idx;
            ptr <= idx == PW'(N - 1) ? '0 : idx + 1'b1;
         end
      end
   end
`ifdef YC_NOC_OUTPORT_CREDIT_EN
   localparam int CRW = $clog2(CRED + 1);
   logic [CRW-1:0] credits;
   assign pop = count != '0 & credits != '0;
   always_ff @(posedge clk) begin
      if (rst) credits <= CRW'(CRED);
      else if (pop & !p.credit_ret) credits <= credits - 1'b1;
      else if (!pop & p.credit_ret & credits != CRW'(CRED)) credits <= credits + 1'b1;
   end
`else
   assign pop = count != '0 & p.out_ready;
`endif
   yc_noc_ofifo #(.DEPTH(DEPTH), .T(flit_t)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(acc),
      .pop(pop),
      .din(din),
      .dout(dout),
      .full(full),
      .empty(empty),
      .count(count)
   );
   assign p.out_valid = !empty;
   assign {p.out_head, p.out_tail, p.out_flit} = dout;
endmodule

// File: tb/tb_yc_noc_outport.sv
// tb_yc_noc_outport: directed vector table plus hand-written reset and credit sequences.
module tb_yc_noc_outport;
   typedef struct {
      logic [4:0] v, h, t;
      logic [31:0] pay;
      logic ordy;
      logic [4:0] ready;
      logic ov;
      logic [31:0] flit;
      logic oh, ot;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_fail = 0;
   yc_noc_outport_if #(.N(5), .FW(32)) bus();
   yc_noc_outport dut(.clk(clk), .rst(rst), .p(bus));
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t, input logic [31:0] pay);
      bus.in_valid = v;
      bus.in_head = h;
      bus.in_tail = t;
      for (int i = 0; i < 5; i++) bus.in_flit[i*32 +: 32] = pay | 32'(i);
   endtask

   task automatic chk_out(input string name, input logic ov, input logic [31:0] flit, input logic oh, input logic ot);
      chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
      chk({name, ".out_flit"}, bus.out_flit, flit);
      chk({name, ".out_head"}, 32'(bus.out_head), 32'(oh));
      chk({name, ".out_tail"}, 32'(bus.out_tail), 32'(ot));
   endtask

   vec_t vt [25];
   int acc_n;

   initial begin
      drive(5'b11111, 5'b11111, 5'b00000, 32'h0);
`ifdef YC_NOC_OUTPORT_CREDIT_EN
      bus.credit_ret = 1'b0;
`else
      bus.out_ready = 1'b1;
`endif
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
         chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(5'b0, 5'b0, 5'b0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("idle.in_ready", 32'(bus.in_ready), 32'h0);
         chk_out("idle", 1'b0, 32'h0, 1'b0, 1'b0);
         @(negedge clk);
      end
`ifndef YC_NOC_OUTPORT_CREDIT_EN
      vt = '{
         '{5'b01010, 5'b01010, 5'b00000, 32'h100, 1'b1, 5'b00010, 1'b0, 32'h0, 1'b0, 1'b0},
         '{5'b01010, 5'b01000, 5'b00000, 32'h200, 1'b1, 5'b00010, 1'b1, 32'h101, 1'b1, 1'b0},
         '{5'b01010, 5'b01000, 5'b00010, 32'h300, 1'b1, 5'b00010, 1'b1, 32'h201, 1'b0, 1'b0},
         '{5'b01000, 5'b01000, 5'b00000, 32'h400, 1'b1, 5'b01000, 1'b1, 32'h301, 1'b0, 1'b1},
         '{5'b01000, 5'b00000, 5'b00000, 32'h500, 1'b1, 5'b01000, 1'b1, 32'h403, 1'b1, 1'b0},
         '{5'b01000, 5'b00000, 5'b01000, 32'h600, 1'b1, 5'b01000, 1'b1, 32'h503, 1'b0, 1'b0},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b1, 32'h603, 1'b0, 1'b1},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0},
         '{5'b11111, 5'b11111, 5'b11111, 32'h700, 1'b1, 5'b10000, 1'b0, 32'h0, 1'b0, 1'b0},
         '{5'b11111, 5'b11111, 5'b11111, 32'h800, 1'b1, 5'b00001, 1'b1, 32'h704, 1'b1, 1'b1},
         '{5'b11111, 5'b11111, 5'b11111, 32'h900, 1'b1, 5'b00010, 1'b1, 32'h800, 1'b1, 1'b1},
         '{5'b11111, 5'b11111, 5'b11111, 32'hA00, 1'b1, 5'b00100, 1'b1, 32'h901, 1'b1, 1'b1},
         '{5'b11111, 5'b11111, 5'b11111, 32'hB00, 1'b1, 5'b01000, 1'b1, 32'hA02, 1'b1, 1'b1},
         '{5'b11111, 5'b11111, 5'b11111, 32'hC00, 1'b1, 5'b10000, 1'b1, 32'hB03, 1'b1, 1'b1},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b1, 32'hC04, 1'b1, 1'b1},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0},
         '{5'b00100, 5'b00000, 5'b00000, 32'hD00, 1'b1, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0},
         '{5'b00011, 5'b00011, 5'b00011, 32'hE00, 1'b0, 5'b00001, 1'b0, 32'h0, 1'b0, 1'b0},
         '{5'b00011, 5'b00011, 5'b00011, 32'hF00, 1'b0, 5'b00010, 1'b1, 32'hE00, 1'b1, 1'b1},
         '{5'b00011, 5'b00011, 5'b00011, 32'h1000, 1'b0, 5'b00000, 1'b1, 32'hE00, 1'b1, 1'b1},
         '{5'b00011, 5'b00011, 5'b00011, 32'h1100, 1'b1, 5'b00000, 1'b1, 32'hE00, 1'b1, 1'b1},
         '{5'b00011, 5'b00011, 5'b00011, 32'h1200, 1'b0, 5'b00001, 1'b1, 32'hF01, 1'b1, 1'b1},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b1, 32'hF01, 1'b1, 1'b1},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b1, 32'h1200, 1'b1, 1'b1},
         '{5'b00000, 5'b00000, 5'b00000, 32'h0, 1'b1, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0}
      };
      for (int r = 0; r < 25; r++) begin
         bus.out_ready = vt[r].ordy;
         drive(vt[r].v, vt[r].h, vt[r].t, vt[r].pay);
         #1;
         chk($sformatf("row%0d.in_ready", r), 32'(bus.in_ready), 32'(vt[r].ready));
         chk_out($sformatf("row%0d", r), vt[r].ov, vt[r].flit, vt[r].oh, vt[r].ot);
         @(negedge clk);
      end
      // Reset while requester 2 owns the port with two flits still buffered.
      bus.out_ready = 1'b0;
      drive(5'b00100, 5'b00100, 5'b00000, 32'h1300);
      #1;
      chk("mid.head.in_ready", 32'(bus.in_ready), 32'b00100);
      @(negedge clk);
      drive(5'b00100, 5'b00000, 5'b00000, 32'h1400);
      #1;
      chk("mid.body.in_ready", 32'(bus.in_ready), 32'b00100);
      chk_out("mid.body", 1'b1, 32'h1302, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(5'b00100, 5'b00000, 5'b00000, 32'h1500);
      #1;
      chk("mid.rst.in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("mid.after.in_ready", 32'(bus.in_ready), 32'h0);
         chk_out("mid.after", 1'b0, 32'h0, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(5'b00100, 5'b00100, 5'b00100, 32'h1600);
      #1;
      chk("mid.newhead.in_ready", 32'(bus.in_ready), 32'b00100);
      @(negedge clk);
      drive(5'b0, 5'b0, 5'b0, 32'h0);
      #1;
      chk_out("mid.newhead", 1'b1, 32'h1602, 1'b1, 1'b1);
`else
      acc_n = 0;
      for (int c = 0; c < 20; c++) begin
         drive(5'b00001, 5'b00001, 5'b00001, 32'(acc_n));
         #1;
         if (bus.in_ready[0]) acc_n++;
         @(negedge clk);
      end
      drive(5'b0, 5'b0, 5'b0, 32'h0);
      #1;
      chk("cred.accepts", 32'(acc_n), 32'd6);
      chk_out("cred.stalled", 1'b1, 32'd4, 1'b1, 1'b1);
      @(negedge clk);
      bus.credit_ret = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.credit_ret = 1'b0;
      #1;
      chk_out("cred.ret1", 1'b1, 32'd5, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      chk_out("cred.drained", 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      drive(5'b00001, 5'b00001, 5'b00001, 32'h99);
      #1;
      chk("cred.push.in_ready", 32'(bus.in_ready), 32'b00001);
      @(negedge clk);
      drive(5'b0, 5'b0, 5'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk_out("cred.empty_credit", 1'b1, 32'h99, 1'b1, 1'b1);
         @(negedge clk);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/yc_noc_outport.md
Name: yc_noc_outport

Overview:
- One router output port: arbitrates among N input-port requesters, forwards wormhole packets (head…tail flits) and buffers them in a small output FIFO toward the link.
- Packet-level round-robin: the winner of a head flit holds the port until its tail flit is accepted.
- Sits directly downstream of the per-input route-compute/input-buffer stage and directly upstream of the inter-router link.

Parameters:
- N, 5, number of input requesters (4 directions plus local).
- FW, 32, flit payload width in bits.
- DEPTH, 2, output FIFO entries (≥2).
- CRED, 4, initial downstream credit count (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  N  flit offered by requester i.
- in_head  input  N  offered flit is a head.
- in_tail  input  N  offered flit is a tail (head&tail means a single-flit packet).
- in_flit  input  N*FW  payloads; requester i occupies bits [i*FW +: FW].
- in_ready  output  N  flit from requester i accepted this cycle (accept = in_valid[i] & in_ready[i]).
- out_valid  output  1  output FIFO head valid.
- out_flit  output  FW  output FIFO head payload.
- out_head  output  1  head flag of out_flit.
- out_tail  output  1  tail flag of out_flit.
- out_ready  input  1  link accepts the output flit (pop = out_valid & out_ready). Absent when YC_NOC_OUTPORT_CREDIT_EN is defined.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- State at reset:
  - ptr=0, unlocked, owner=0, FIFO empty (count=0).
  - out_valid=0; out_flit, out_head and out_tail all 0.
  - in_ready forced to 0 while rst=1.
- Unlocked state:
  - Candidates are cand[i] = in_valid[i] & in_head[i].
  - Winner is the first set cand at index (ptr+k)%N, k=0..N-1.
  - A non-head valid flit while unlocked is never granted; it is held with in_ready=0.
- Locked state:
  - Only the owner is eligible, with any flit type.
  - Other requesters see in_ready=0.
- in_ready:
  - in_ready[i] = !full & (locked ? owner==i : winner==i).
  - It is combinational from the in_* inputs and registered state. It never depends on out_ready.
  - At most one bit of in_ready is set per cycle.
- Accept of a head without tail: locked<=1, owner<=i, ptr<=(i+1)%N.
- Accept of a head with tail (single flit): ptr<=(i+1)%N, lock stays 0.
- Accept of a tail while locked: locked<=0. A new head can be granted from the next cycle, not the same cycle.
- The pointer moves only on head accept. There is no pointer update on stalls or body flits.
- FIFO:
  - Push on accept, pop on out_valid&out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - full = (count==DEPTH). A push is refused when full, even if a pop occurs that cycle.
  - Occupancy width is $clog2(DEPTH+1).
  - Read and write pointers wrap modulo DEPTH.
- Latency: a flit accepted in cycle t is visible on out_* in cycle t+1 when the FIFO was empty. The port has no combinational path from in_* to out_*.
- Ordering: flits leave in acceptance order. Packets are never interleaved on the output.
- Reset mid-packet: lock and FIFO contents are discarded. Recovering the truncated packet is the upstream protocol's responsibility.

Optional Feature:
- Macro: YC_NOC_OUTPORT_CREDIT_EN.
- When defined:
  - out_ready is removed and replaced by input credit_ret (1 bit, one credit returned per cycle when high).
  - A credit counter resets to CRED.
  - pop = out_valid & (credits!=0); each pop decrements the counter and each credit_ret increments it. Pop and credit_ret in the same cycle leave it unchanged.
  - The counter saturates at CRED.
  - The counter's width is $clog2(CRED+1).
- When undefined: plain valid/ready output as described above.

Decomposition:
- Package yc_noc_pkg holds:
  - typedef yc_flit_t (struct: head, tail, payload[FW-1:0]);
  - localparams for default N, FW and DEPTH;
  - a function rr_pick(req, ptr) returning a one-hot winner.
- One sub-module, yc_noc_ofifo: a parameterised DEPTH×yc_flit_t synchronous FIFO with push/pop/full/empty/count.
- Arbitration, lock and the credit logic live in the top module.

Test Plan:
- Reset, then 2 idle cycles → out_valid=0, in_ready=0 during rst, ptr=0, count=0.
- Requesters 1 and 3 each offer a 3-flit packet in the same cycle → packet 1 is accepted first. Output flit order is 1H,1B,1T,3H,3B,3T, with no interleaving, and 3H is accepted the cycle after 1T.
- All 5 requesters continuously offer single-flit packets → grants rotate 0,1,2,3,4,0. Each requester gets one grant per 5 accepts.
- Hold out_ready=0 with DEPTH=2 → after 2 accepts in_ready=0 on all ports. Raise out_ready → out_flit sequence is preserved and acceptance resumes one cycle later.
- Assert rst mid-packet (owner=2, after the body flit) → next cycle out_valid=0. A body flit from requester 2 is refused (in_ready=0) until a head arrives.
- With YC_NOC_OUTPORT_CREDIT_EN, CRED=4 and no credit_ret, push 6 flits → exactly 4 pops. Pulse credit_ret twice → 2 more pops, and the counter ends at 0.
